multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
- Multicycle sequencer for the RV32I-subset datapath: add, sub, and, or, addi, lw, sw, beq.
- Drives mux selects, register, PC, IR and memory enables, and the 2-bit ALUOp consumed by the ALU control decoder.
- Handles the instruction/data memory handshake with a timeout, traps unsupported opcodes, and counts retired instructions.

Parameters:
- MEM_TIMEOUT, 15: maximum wait cycles for mem_ready per access before a trap; legal range 1..255.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- opcode  in  7  IR[6:0] of the latched instruction.
- zero  in  1  ALU zero flag (valid in the BRANCH state).
- mem_ready  in  1  memory access completes this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  write strobe (valid with mem_req).
- iord  out  1  address select: 0=PC, 1=ALUOut.
- ir_write  out  1  load IR with read data.
- pc_write  out  1  PC load enable.
- pc_src  out  1  PC source: 0=ALU result (PC+4), 1=branch target.
- alu_src_a  out  1  ALU A select: 0=PC, 1=rs1.
- alu_src_b  out  2  ALU B select: 00=rs2, 01=const 4, 10=imm.
- alu_op  out  2  ALUOp: 00=add, 01=sub/branch, 10=R-type decode.
- reg_write  out  1  register-file write enable.
- mem_to_reg  out  1  writeback source: 0=ALUOut, 1=MDR.
- illegal  out  1  one-cycle pulse on an unsupported opcode.
- timeout  out  1  one-cycle pulse on a memory timeout.
- state  out  4  current state, for debug.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- Reset: when rst_n=0 at a clk edge:
  - state=FETCH(0), instret=0, wait counter=0.
  - All outputs are 0 except those FETCH drives, which are Moore-decoded from state.
  - Reset mid-access abandons the access. mem_req stays high because FETCH re-requests.
- State encoding: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_ADDR=4, MEM_RD=5, MEM_WR=6, WB_MEM=7, WB_ALU=8, BRANCH=9, TRAP=10. Codes 11..15 go to FETCH.
- Default for every output is 0 in every state. Each state asserts only what is listed below.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00.
  - ir_write and pc_write are asserted only in the cycle mem_ready=1; that cycle moves to DECODE.
- DECODE (1 cycle), next state by opcode:
  - 0110011 -> EXEC_R.
  - 0010011 -> EXEC_I.
  - 0000011 or 0100011 -> MEM_ADDR.
  - 1100011 -> BRANCH.
  - anything else -> TRAP.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10 -> WB_ALU.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=00 -> WB_ALU.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00.
  - Goes to MEM_RD if opcode=0000011, else MEM_WR.
  - opcode is held stable by the IR.
- MEM_RD: mem_req=1, iord=1. Moves to WB_MEM on mem_ready.
- MEM_WR: mem_req=1, mem_we=1, iord=1. Moves to FETCH on mem_ready (retire).
- WB_MEM: reg_write=1, mem_to_reg=1 -> FETCH (retire).
- WB_ALU: reg_write=1, mem_to_reg=0 -> FETCH (retire).
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=1, pc_write=zero (the only Mealy output) -> FETCH (retire).
- TRAP: illegal=1, or timeout=1 if entered by timeout -> FETCH. Nothing retires.
- Cycles per instruction, with zero-wait memory:
  - lw 5; sw 4; R-type and addi 4; beq 3.
- Wait counter:
  - Clears on entry to FETCH, MEM_RD and MEM_WR.
  - Increments each cycle mem_ready=0 in those states.
  - If the counter reaches MEM_TIMEOUT with mem_ready still 0, next state is TRAP with timeout flagged.
  - mem_ready=1 in the same cycle the counter reaches MEM_TIMEOUT counts as success; ready wins.
  - A trap during FETCH performs no PC or IR write.
- instret:
  - Increments by 1 on each transition into FETCH from MEM_WR, WB_MEM, WB_ALU or BRANCH.
  - Wraps modulo 2^CNT_W.
- mem_ready outside FETCH, MEM_RD and MEM_WR is ignored.

Test Plan:
- Reset, then opcode=0110011 and mem_ready held 1 -> states 0,1,2,8,0.
  - ir_write=pc_write=1 in cycle 0; alu_op=10 in EXEC_R; reg_write=1 in WB_ALU; instret=1 after 4 cycles.
- lw (0000011), mem_ready 1 in FETCH, MEM_RD stalled 3 cycles -> sequence 0,1,4,5,5,5,5,7,0.
  - iord=1 only in MEM_RD; mem_to_reg=1 and reg_write=1 in WB_MEM.
- beq (1100011), zero=1, then repeated with zero=0 -> alu_op=01 and pc_src=1 in BRANCH.
  - pc_write=1 only when zero=1; both runs take 3 cycles and increment instret.
- opcode=1111111 -> DECODE then TRAP; illegal pulses exactly 1 cycle; back to FETCH; instret unchanged.
- MEM_TIMEOUT=15, sw with mem_ready never asserted in MEM_WR -> after 15 wait cycles timeout=1 for 1 cycle in TRAP.
  - Rerun with mem_ready arriving on exactly the 15th wait cycle -> goes to FETCH, no timeout.
- rst_n=0 for one edge while in MEM_RD -> next state FETCH, instret=0, reg_write never asserted.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multicycle control sequencer for an RV32I-subset datapath (add/sub/and/or/addi/lw/sw/beq).
// Waits on memory with a bounded timeout, traps unsupported opcodes and counts retired instructions.
//
// state    | meaning
// FETCH    | read instruction at PC, write IR and PC+4 on mem_ready
// DECODE   | select the execute path from the opcode
// EXEC_R   | rs1 op rs2, ALU control decodes funct fields
// EXEC_I   | rs1 + imm
// MEM_ADDR | rs1 + imm as the load/store address
// MEM_RD   | data read at ALUOut
// MEM_WR   | data write at ALUOut, retires on mem_ready
// WB_MEM   | write MDR to rd, retires
// WB_ALU   | write ALUOut to rd, retires
// BRANCH   | compare rs1/rs2, load branch target when zero, retires
// TRAP     | pulse illegal or timeout, then refetch
module multicycle_control_fsm #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             illegal,
    output logic             timeout,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_MEM   = 4'd7,
        S_WB_ALU   = 4'd8,
        S_BRANCH   = 4'd9,
        S_TRAP     = 4'd10
    } state_e;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    // The trap fires on the wait cycle that would bring the count to MEM_TIMEOUT.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic             timeout_flag_q, timeout_flag_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic mem_wait;
    logic expired;
    logic retire;

    assign mem_wait = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    assign expired  = mem_wait && !mem_ready && (wait_cnt_q == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_FETCH;
            wait_cnt_q     <= '0;
            timeout_flag_q <= 1'b0;
            instret_q      <= '0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            timeout_flag_q <= timeout_flag_d;
            instret_q      <= instret_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        timeout_flag_d = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (expired) begin
                    state_d        = S_TRAP;
                    timeout_flag_d = 1'b1;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_R:         state_d = S_EXEC_R;
                    OP_I:         state_d = S_EXEC_I;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_EXEC_R:   state_d = S_WB_ALU;
            S_EXEC_I:   state_d = S_WB_ALU;
            S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (mem_ready) begin
                    state_d = S_WB_MEM;
                end else if (expired) begin
                    state_d        = S_TRAP;
                    timeout_flag_d = 1'b1;
                end
            end
            S_MEM_WR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else if (expired) begin
                    state_d        = S_TRAP;
                    timeout_flag_d = 1'b1;
                end
            end
            S_WB_MEM:   state_d = S_FETCH;
            S_WB_ALU:   state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_TRAP:     state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_d != state_q) begin
            wait_cnt_d = '0;
        end else if (mem_wait && !mem_ready) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end

    assign retire = (state_d == S_FETCH) &&
                    ((state_q == S_MEM_WR) || (state_q == S_WB_MEM) ||
                     (state_q == S_WB_ALU) || (state_q == S_BRANCH));

    always_comb begin
        instret_d = instret_q;
        if (retire) begin
            instret_d = instret_q + CNT_W'(1);
        end
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;
        timeout    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_EXEC_I, S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_WB_ALU: begin
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 1'b1;
                pc_write  = zero;
            end
            S_TRAP: begin
                illegal = !timeout_flag_q;
                timeout = timeout_flag_q;
            end
            default: begin
            end
        endcase
    end

    assign state   = state_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: instruction-level model expands each instruction
// and its memory latencies into an expected per-cycle trace, compared against the DUT.
module tb_multicycle_control_fsm;

    localparam int T     = 15;
    localparam int CNT_W = 5;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_EXEC_R = 4'd2, ST_EXEC_I = 4'd3,
                           ST_MEM_ADDR = 4'd4, ST_MEM_RD = 4'd5, ST_MEM_WR = 4'd6,
                           ST_WB_MEM = 4'd7, ST_WB_ALU = 4'd8, ST_BRANCH = 4'd9, ST_TRAP = 4'd10;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [6:0]       opcode;
    logic             zero;
    logic             mem_ready;
    logic             mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a;
    logic [1:0]       alu_src_b, alu_op;
    logic             reg_write, mem_to_reg, illegal, timeout;
    logic [3:0]       state;
    logic [CNT_W-1:0] instret;

    int n_tests = 0;
    int n_fail  = 0;

    bit               rdy_q[$];
    bit               z_q[$];
    bit               rst_q[$];
    logic [6:0]       op_q[$];
    logic [18:0]      exp_q[$];
    logic [18:0]      obs_q[$];
    logic [CNT_W-1:0] exp_ir_q[$];
    logic [CNT_W-1:0] obs_ir_q[$];
    logic [CNT_W-1:0] exp_instret;

    multicycle_control_fsm #(.MEM_TIMEOUT(T), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .illegal    (illegal),
        .timeout    (timeout),
        .state      (state),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    // Control word a state must present: {state, mem_req, mem_we, iord, ir_write, pc_write,
    // pc_src, alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg, illegal, timeout}.
    function automatic logic [18:0] exp_vec(input logic [3:0] s, input bit rdy, input bit z, input bit tf);
        logic mreq, mwe, io, irw, pcw, pcs, asa, rw, m2r, ill, to;
        logic [1:0] asb, aop;
        {mreq, mwe, io, irw, pcw, pcs, asa, rw, m2r, ill, to} = '0;
        asb = 2'b00;
        aop = 2'b00;
        case (s)
            ST_FETCH:    begin mreq = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
            ST_EXEC_R:   begin asa = 1; asb = 2'b00; aop = 2'b10; end
            ST_EXEC_I:   begin asa = 1; asb = 2'b10; end
            ST_MEM_ADDR: begin asa = 1; asb = 2'b10; end
            ST_MEM_RD:   begin mreq = 1; io = 1; end
            ST_MEM_WR:   begin mreq = 1; mwe = 1; io = 1; end
            ST_WB_MEM:   begin rw = 1; m2r = 1; end
            ST_WB_ALU:   begin rw = 1; end
            ST_BRANCH:   begin asa = 1; aop = 2'b01; pcs = 1; pcw = z; end
            ST_TRAP:     begin ill = !tf; to = tf; end
            default:     begin end
        endcase
        return {s, mreq, mwe, io, irw, pcw, pcs, asa, asb, aop, rw, m2r, ill, to};
    endfunction

    task automatic clear_trace();
        rdy_q.delete(); z_q.delete(); rst_q.delete(); op_q.delete();
        exp_q.delete(); obs_q.delete(); exp_ir_q.delete(); obs_ir_q.delete();
    endtask

    task automatic push(input logic [3:0] s, input bit rdy, input bit z, input bit tf,
                        input logic [6:0] op, input bit rst);
        rdy_q.push_back(rdy);
        z_q.push_back(z);
        op_q.push_back(op);
        rst_q.push_back(rst);
        exp_q.push_back(exp_vec(s, rdy, z, tf));
        exp_ir_q.push_back(exp_instret);
    endtask

    task automatic bump_instret();
        exp_instret = CNT_W'((int'(exp_instret) + 1) % (1 << CNT_W));
    endtask

    // A memory access of latency lat: ready on cycle lat, or a timeout trap after T idle cycles.
    task automatic add_wait(input logic [3:0] s, input int lat, input bit z, input logic [6:0] op,
                            output bit ok);
        if (lat <= T) begin
            for (int k = 1; k <= lat; k++) push(s, k == lat, z, 0, op, 1);
            ok = 1;
        end else begin
            for (int k = 1; k <= T; k++) push(s, 0, z, 0, op, 1);
            push(ST_TRAP, bit'($urandom_range(0, 1)), z, 1, op, 1);
            ok = 0;
        end
    endtask

    task automatic add_instr(input logic [6:0] op, input bit z, input int flat, input int mlat);
        bit ok;
        add_wait(ST_FETCH, flat, z, op, ok);
        if (!ok) return;
        push(ST_DECODE, bit'($urandom_range(0, 1)), z, 0, op, 1);
        case (op)
            OP_R: begin
                push(ST_EXEC_R, bit'($urandom_range(0, 1)), z, 0, op, 1);
                push(ST_WB_ALU, bit'($urandom_range(0, 1)), z, 0, op, 1);
                bump_instret();
            end
            OP_I: begin
                push(ST_EXEC_I, bit'($urandom_range(0, 1)), z, 0, op, 1);
                push(ST_WB_ALU, bit'($urandom_range(0, 1)), z, 0, op, 1);
                bump_instret();
            end
            OP_LW: begin
                push(ST_MEM_ADDR, bit'($urandom_range(0, 1)), z, 0, op, 1);
                add_wait(ST_MEM_RD, mlat, z, op, ok);
                if (ok) begin
                    push(ST_WB_MEM, bit'($urandom_range(0, 1)), z, 0, op, 1);
                    bump_instret();
                end
            end
            OP_SW: begin
                push(ST_MEM_ADDR, bit'($urandom_range(0, 1)), z, 0, op, 1);
                add_wait(ST_MEM_WR, mlat, z, op, ok);
                if (ok) bump_instret();
            end
            OP_BEQ: begin
                push(ST_BRANCH, bit'($urandom_range(0, 1)), z, 0, op, 1);
                bump_instret();
            end
            default: push(ST_TRAP, bit'($urandom_range(0, 1)), z, 0, op, 1);
        endcase
    endtask

    task automatic add_tail();
        push(ST_FETCH, 0, 0, 0, 7'd0, 1);
    endtask

    // Leaves rst_n low at a negedge, just after a reset edge.
    task automatic apply_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        exp_instret = '0;
        clear_trace();
    endtask

    task automatic drive_trace();
        for (int i = 0; i < rdy_q.size(); i++) begin
            rst_n     = rst_q[i];
            mem_ready = rdy_q[i];
            zero      = z_q[i];
            opcode    = op_q[i];
            #1;
            obs_q.push_back({state, mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a,
                             alu_src_b, alu_op, reg_write, mem_to_reg, illegal, timeout});
            obs_ir_q.push_back(instret);
            @(negedge clk);
        end
        rst_n     = 1'b1;
        mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_ready = 1'b0; opcode = '0; zero = 1'b0;
        exp_instret = '0;
        @(negedge clk);
        #1;
        n_tests++;
        if (state !== ST_FETCH) begin
            n_fail++; $display("FAIL reset_state: got %0d, expected %0d", state, ST_FETCH);
        end
        n_tests++;
        if (instret !== '0) begin
            n_fail++; $display("FAIL reset_instret: got %0d, expected 0", instret);
        end
        n_tests++;
        if ({state, mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a, alu_src_b, alu_op,
             reg_write, mem_to_reg, illegal, timeout} !== exp_vec(ST_FETCH, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL reset_outputs: got mem_req=%b alu_src_b=%b reg_write=%b illegal=%b, expected fetch word %h",
                     mem_req, alu_src_b, reg_write, illegal, exp_vec(ST_FETCH, 0, 0, 0));
        end
    endtask

    task automatic test_rtype();
        apply_reset();
        add_instr(OP_R, 0, 1, 1);
        add_tail();
        drive_trace();
        for (int i = 0; i < exp_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i] || obs_ir_q[i] !== exp_ir_q[i]) begin
                n_fail++;
                $display("FAIL rtype cyc %0d: got word %h instret %0d, expected word %h instret %0d",
                         i, obs_q[i], obs_ir_q[i], exp_q[i], exp_ir_q[i]);
            end
        end
    endtask

    task automatic test_lw_stall();
        apply_reset();
        add_instr(OP_LW, 0, 1, 4);
        add_instr(OP_I, 1, 2, 1);
        add_tail();
        drive_trace();
        for (int i = 0; i < exp_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i] || obs_ir_q[i] !== exp_ir_q[i]) begin
                n_fail++;
                $display("FAIL lw_stall cyc %0d: got word %h instret %0d, expected word %h instret %0d",
                         i, obs_q[i], obs_ir_q[i], exp_q[i], exp_ir_q[i]);
            end
        end
    endtask

    task automatic test_branch();
        apply_reset();
        add_instr(OP_BEQ, 1, 1, 1);
        add_instr(OP_BEQ, 0, 1, 1);
        add_tail();
        drive_trace();
        for (int i = 0; i < exp_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i] || obs_ir_q[i] !== exp_ir_q[i]) begin
                n_fail++;
                $display("FAIL branch cyc %0d: got word %h instret %0d, expected word %h instret %0d",
                         i, obs_q[i], obs_ir_q[i], exp_q[i], exp_ir_q[i]);
            end
        end
    endtask

    task automatic test_illegal();
        apply_reset();
        add_instr(OP_R, 0, 1, 1);
        add_instr(7'b1111111, 0, 1, 1);
        add_tail();
        drive_trace();
        for (int i = 0; i < exp_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i] || obs_ir_q[i] !== exp_ir_q[i]) begin
                n_fail++;
                $display("FAIL illegal cyc %0d: got word %h instret %0d, expected word %h instret %0d",
                         i, obs_q[i], obs_ir_q[i], exp_q[i], exp_ir_q[i]);
            end
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        add_instr(OP_SW, 0, 1, T + 1);
        add_instr(OP_SW, 0, 1, T);
        add_instr(OP_R, 0, T + 1, 1);
        add_instr(OP_LW, 0, T, T);
        add_instr(OP_LW, 0, 1, T + 1);
        add_tail();
        drive_trace();
        for (int i = 0; i < exp_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i] || obs_ir_q[i] !== exp_ir_q[i]) begin
                n_fail++;
                $display("FAIL timeout cyc %0d: got word %h instret %0d, expected word %h instret %0d",
                         i, obs_q[i], obs_ir_q[i], exp_q[i], exp_ir_q[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        add_instr(OP_R, 0, 1, 1);
        push(ST_FETCH, 1, 0, 0, OP_LW, 1);
        push(ST_DECODE, 0, 0, 0, OP_LW, 1);
        push(ST_MEM_ADDR, 1, 0, 0, OP_LW, 1);
        push(ST_MEM_RD, 0, 0, 0, OP_LW, 1);
        push(ST_MEM_RD, 0, 0, 0, OP_LW, 0);
        exp_instret = '0;
        push(ST_FETCH, 0, 0, 0, OP_LW, 1);
        push(ST_FETCH, 0, 0, 0, OP_LW, 1);
        drive_trace();
        for (int i = 0; i < exp_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i] || obs_ir_q[i] !== exp_ir_q[i]) begin
                n_fail++;
                $display("FAIL mid_reset cyc %0d: got word %h instret %0d, expected word %h instret %0d",
                         i, obs_q[i], obs_ir_q[i], exp_q[i], exp_ir_q[i]);
            end
        end
    endtask

    function automatic int pick_lat();
        if ($urandom_range(0, 9) < 6) return 1;
        return int'($urandom_range(2, T + 1));
    endfunction

    task automatic test_random();
        logic [6:0] op;
        apply_reset();
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 5))
                0: op = OP_R;
                1: op = OP_I;
                2: op = OP_LW;
                3: op = OP_SW;
                4: op = OP_BEQ;
                default: begin
                    op = 7'($urandom);
                    while (op == OP_R || op == OP_I || op == OP_LW || op == OP_SW || op == OP_BEQ)
                        op = 7'($urandom);
                end
            endcase
            add_instr(op, bit'($urandom_range(0, 1)), pick_lat(), pick_lat());
        end
        add_tail();
        drive_trace();
        for (int i = 0; i < exp_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i] || obs_ir_q[i] !== exp_ir_q[i]) begin
                n_fail++;
                $display("FAIL random cyc %0d: got word %h instret %0d, expected word %h instret %0d",
                         i, obs_q[i], obs_ir_q[i], exp_q[i], exp_ir_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_stall();
        test_branch();
        test_illegal();
        test_timeout();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
